keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Responder end of the 4x4 matrix keypad interface: stands in for a physical keypad so the column-scanning keypad controller can be exercised in simulation, or driven from a host in hardware.
- Accepts ASCII key codes through a valid/ready handshake and queues them in a small FIFO.
- Presses each queued key for a programmable time by pulling the matching row line low while its column is driven low, then releases it for a programmable gap.

Parameters:
PRESS_CYCLES, 64, clocks each key is held pressed (>=1)
GAP_CYCLES, 64, clocks of all-keys-released between successive presses (>=1)
FIFO_DEPTH, 4, key-code queue depth, power of two, >=2

Ports:
clk  in  1  system clock, all state updates on rising edge
resetn  in  1  synchronous, active-low reset
keycode  in  8  ASCII code of the key to press
keyvalid  in  1  keycode is valid this cycle
keyready  out  1  FIFO can accept a code (not full)
column  in  4  active-low column drive from the scanner
row  out  4  active-low row sense returned to the scanner
keyheld  out  8  ASCII code currently pressed; 0 when none
busy  out  1  FIFO non-empty or a press/gap is in progress
badkey  out  1  one-cycle pulse: dequeued code not in the key map

Behaviour:
- Reset (resetn=0 at a rising edge): FIFO emptied, state IDLE, counters 0, keyheld=0, busy=0, badkey=0, keyready=1. row=4'hF, because no key is held. Reset mid-press releases the key on the same edge.
- Key map, as (column index c, row index r); the key is pressed when column[c]=0:
  - c0: '1' r0, '4' r1, '7' r2, '0' r3
  - c1: '2' r0, '5' r1, '8' r2, 'F' r3
  - c2: '3' r0, '6' r1, '9' r2, 'E' r3
  - c3: 'A' r0, 'B' r1, 'C' r2, 'D' r3
  - Codes are uppercase only. Every other code is invalid.
- row is combinational, with zero latency from column:
  - row[r] = 0 only when in PRESS, r = held row and column[held c] = 0.
  - All other row bits are 1.
  - Reason: the scanner samples row on the edge immediately after changing column, so row must not be registered.
  - If several columns are low at once, the held key still asserts its row whenever its own column is low.
- FIFO:
  - Push when keyvalid & keyready. keyready = !full. A push while full is impossible by construction.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE: if FIFO non-empty, pop and decode at this edge.
    - Valid code: load held c/r, keyheld=code, counter=PRESS_CYCLES-1, go to PRESS.
    - Invalid code: badkey=1 for this one cycle, code discarded, stay IDLE. The next entry is popped on the following edge.
  - PRESS: key asserted for exactly PRESS_CYCLES clocks.
    - Counter decrements each clock.
    - At 0: keyheld=0, counter=GAP_CYCLES-1, go to GAP.
  - GAP: row all 1s for exactly GAP_CYCLES clocks. At 0, go to IDLE.
  - Illegal state encoding: go to IDLE with keyheld=0.
- Latency: a code pushed at edge N into an empty FIFO in IDLE is in PRESS from edge N+1 to edge N+1+PRESS_CYCLES.
- busy = (FIFO count != 0) | (state != IDLE).
- Counter width is clog2 of max(PRESS_CYCLES, GAP_CYCLES)+1. There is no overflow path.

Test Plan:
- Reset then push '5' (0x35); scanner drives column=4'b1101 -> row=4'b1101 for exactly 64 clocks, row=4'hF under every other column, keyheld=0x35 during the press, then 64 gap clocks with row=4'hF, busy=0.
- Loop: the scanner controller cycles through columns 14/13/11/7 as its scan states advance; the emulator queues '1','F','C','0' -> the scanner's keydata shows 0x31, 0x46, 0x43, 0x30 in order.
- Push 5 codes back-to-back with FIFO_DEPTH=4 while IDLE -> keyready drops low after the FIFO fills; no code lost; all presses occur in push order.
- Push 'a' (0x61) then '9' -> badkey pulses once with row never asserted; '9' is then pressed with column=4'b1011 giving row=4'b1011.
- Deassert resetn at press clock 10 -> row=4'hF, keyheld=0, keyready=1 at the next edge; queued codes are discarded.
- Drive column=4'b0000 while 'D' is held -> row=4'b0111; with column=4'b0111 also row=4'b0111; with column=4'b1111, row=4'hF.

Source files
------------

// File: rtl/keypad_emulator_if.sv
// Host-side key-code handshake of the keypad emulator: the host offers an
// ASCII code with keyvalid and the emulator accepts it while keyready is high.
`timescale 1ns/1ps

interface keypad_emulator_if;
    logic [7:0] keycode;
    logic       keyvalid;
    logic       keyready;

    modport master (output keycode, output keyvalid, input keyready);
    modport slave  (input keycode, input keyvalid, output keyready);
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: queues ASCII key codes from a host and plays
// each one back as a timed key press on the active-low row/column matrix,
// followed by an all-released gap, so a column scanner sees a real keypad.
`timescale 1ns/1ps

module keypad_emulator #(
    parameter int PRESS_CYCLES = 64,
    parameter int GAP_CYCLES   = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    keypad_emulator_if.slave        host,
    input  logic [3:0]              column,
    output logic [3:0]              row,
    output logic [7:0]              keyheld,
    output logic                    busy,
    output logic                    badkey
);

    localparam int MAX_CYCLES = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Position of a key in the matrix plus a flag saying the code is mapped.
    typedef struct packed {
        logic       valid;
        logic [1:0] col;
        logic [1:0] rw;
    } key_pos_t;

    // Key map: column index selects the scanned column, row index the sense line.
    function automatic key_pos_t decode(input logic [7:0] code);
        key_pos_t p;
        p = '{valid: 1'b1, col: 2'd0, rw: 2'd0};
        case (code)
            8'h31: begin p.col = 2'd0; p.rw = 2'd0; end  // '1'
            8'h34: begin p.col = 2'd0; p.rw = 2'd1; end  // '4'
            8'h37: begin p.col = 2'd0; p.rw = 2'd2; end  // '7'
            8'h30: begin p.col = 2'd0; p.rw = 2'd3; end  // '0'
            8'h32: begin p.col = 2'd1; p.rw = 2'd0; end  // '2'
            8'h35: begin p.col = 2'd1; p.rw = 2'd1; end  // '5'
            8'h38: begin p.col = 2'd1; p.rw = 2'd2; end  // '8'
            8'h46: begin p.col = 2'd1; p.rw = 2'd3; end  // 'F'
            8'h33: begin p.col = 2'd2; p.rw = 2'd0; end  // '3'
            8'h36: begin p.col = 2'd2; p.rw = 2'd1; end  // '6'
            8'h39: begin p.col = 2'd2; p.rw = 2'd2; end  // '9'
            8'h45: begin p.col = 2'd2; p.rw = 2'd3; end  // 'E'
            8'h41: begin p.col = 2'd3; p.rw = 2'd0; end  // 'A'
            8'h42: begin p.col = 2'd3; p.rw = 2'd1; end  // 'B'
            8'h43: begin p.col = 2'd3; p.rw = 2'd2; end  // 'C'
            8'h44: begin p.col = 2'd3; p.rw = 2'd3; end  // 'D'
            default: p.valid = 1'b0;
        endcase
        return p;
    endfunction

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic [1:0]         held_col;
    logic [1:0]         held_row;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [7:0]         head;
    key_pos_t           head_pos;

    assign full          = (level == FULL_LVL);
    assign empty         = (level == '0);
    assign host.keyready = !full;
    assign push          = host.keyvalid && !full;
    assign pop           = (state == IDLE) && !empty;
    assign head          = mem[rd_ptr];
    assign head_pos      = decode(head);

    // Key-code storage, written only on an accepted push.
    // NOTE: the array has no reset -- an entry is only read after level shows
    // it was written, so clearing it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host.keycode;
        end
    end

    // FIFO pointers and fill level; simultaneous push and pop leave level unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic: a mapped code starts a press, press and gap end when the counter hits zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop && head_pos.valid) state_nxt = PRESS;
            PRESS:   if (count == '0)           state_nxt = GAP;
            GAP:     if (count == '0)           state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Press datapath: latch the popped key, run the press/gap counter, flag unmapped codes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count    <= '0;
            held_col <= '0;
            held_row <= '0;
            keyheld  <= '0;
            badkey   <= 1'b0;
        end else begin
            badkey <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_pos.valid) begin
                            held_col <= head_pos.col;
                            held_row <= head_pos.rw;
                            keyheld  <= head;
                            count    <= PRESS_LOAD;
                        end else begin
                            badkey <= 1'b1;
                        end
                    end
                end
                PRESS: begin
                    if (count == '0) begin
                        keyheld <= '0;
                        count   <= GAP_LOAD;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (count != '0) count <= count - CNT_W'(1);
                end
                default: begin
                    keyheld <= '0;
                    count   <= '0;
                end
            endcase
        end
    end

    // Outputs: row follows column with no register so the scanner sees it on the next edge.
    // NOTE: every output gets its default first so no path through this block infers a latch.
    always_comb begin
        row  = 4'hF;
        busy = !empty || (state != IDLE);
        if ((state == PRESS) && !column[held_col]) begin
            row[held_row] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: a scoreboard queue holds the codes
// expected to be pressed, in push order, and is checked at each press onset.
`timescale 1ns/1ps

module tb_keypad_emulator;

    localparam int PRESS = 64;
    localparam int GAP   = 64;
    localparam int DEPTH = 4;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] column = 4'hF;
    logic [3:0] row;
    logic [7:0] keyheld;
    logic       busy;
    logic       badkey;

    keypad_emulator_if host();

    keypad_emulator #(
        .PRESS_CYCLES (PRESS),
        .GAP_CYCLES   (GAP),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .host    (host),
        .column  (column),
        .row     (row),
        .keyheld (keyheld),
        .busy    (busy),
        .badkey  (badkey)
    );

    always #5 clk = ~clk;

    // Matrix layout, indexed by col*4 + row.
    logic [7:0] keymap [16] = '{8'h31, 8'h34, 8'h37, 8'h30,
                                8'h32, 8'h35, 8'h38, 8'h46,
                                8'h33, 8'h36, 8'h39, 8'h45,
                                8'h41, 8'h42, 8'h43, 8'h44};

    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [7:0] exp_q [$];
    logic [7:0] prev_held = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_key(input logic [7:0] code);
        for (int i = 0; i < 16; i++) if (keymap[i] == code) return 1'b1;
        return 1'b0;
    endfunction

    // What a scanner reads: the low column and the low row select one key.
    function automatic logic [7:0] scan_decode(input logic [3:0] col, input logic [3:0] rw);
        int c = 0;
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if (!col[i]) c = i;
            if (!rw[i])  r = i;
        end
        return keymap[c*4 + r];
    endfunction

    // Offer one code and hold it until accepted; mapped codes join the scoreboard.
    task automatic push_key(input logic [7:0] code);
        int waited = 0;
        host.keycode  = code;
        host.keyvalid = 1'b1;
        while (!host.keyready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!host.keyready) check("push_accept", host.keyready, 1);
        @(posedge clk);
        if (is_key(code)) exp_q.push_back(code);
        #1 host.keyvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || badkey) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic wait_held(input int budget);
        int n = 0;
        while (keyheld == 8'h00 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("press_started", keyheld != 8'h00, 1);
    endtask

    // Scoreboard compare at every press onset.
    always @(negedge clk) begin
        if (resetn && keyheld != 8'h00 && prev_held == 8'h00) begin
            if (exp_q.size() == 0) check("press_unexpected", keyheld, 0);
            else                   check("press_order", keyheld, exp_q.pop_front());
        end
        prev_held = keyheld;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         press_n, held_n, gap_n, other_bad, quiet, bad_n, row_early, stray;
        bit         seen;
        logic [7:0] k;
        logic [7:0] got [$];
        logic [3:0] scan [4]     = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] scan_exp [4] = '{8'h31, 8'h46, 8'h43, 8'h30};

        host.keycode  = 8'h00;
        host.keyvalid = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_keyready", host.keyready, 1);
        check("rst_busy",     busy,          0);
        check("rst_row",      row,           4'hF);
        check("rst_keyheld",  keyheld,       0);
        check("rst_badkey",   badkey,        0);
        resetn = 1'b1;
        @(negedge clk);

        // Single press of '5' on column 1: exact press and gap lengths.
        column = 4'b1101;
        push_key(8'h35);
        press_n = 0; held_n = 0; gap_n = 0; other_bad = 0; seen = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (row == 4'b1101) begin
                press_n++;
                seen = 1'b1;
            end else if (seen && busy) begin
                gap_n++;
            end
            if (keyheld == 8'h35) held_n++;
            column = 4'b1110; #1 if (row != 4'hF) other_bad++;
            column = 4'b1011; #1 if (row != 4'hF) other_bad++;
            column = 4'b0111; #1 if (row != 4'hF) other_bad++;
            column = 4'b1101;
        end
        check("t1_press_len",  press_n,   PRESS);
        check("t1_held_len",   held_n,    PRESS);
        check("t1_gap_len",    gap_n,     GAP);
        check("t1_other_cols", other_bad, 0);
        check("t1_busy_end",   busy,      0);

        // Scanner cycling columns 14/13/11/7 reads back '1','F','C','0'.
        column = 4'hF;
        push_key(8'h31);
        push_key(8'h46);
        push_key(8'h43);
        push_key(8'h30);
        quiet = 100;
        for (int i = 0; i < 2000 && (busy || i < 4); i++) begin
            @(negedge clk);
            column = scan[i % 4];
            #1;
            if (row != 4'hF) begin
                k = scan_decode(column, row);
                if (quiet >= 8) got.push_back(k);
                quiet = 0;
            end else begin
                quiet++;
            end
        end
        column = 4'hF;
        check("t2_scan_count", got.size(), 4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t2_scan_key%0d", j), (j < got.size()) ? got[j] : 8'h00, scan_exp[j]);
        end
        wait_idle(20);

        // Five back-to-back pushes fill a depth-4 FIFO; order must survive.
        push_key(8'h32);
        push_key(8'h33);
        push_key(8'h34);
        push_key(8'h36);
        push_key(8'h37);
        check("t3_full_keyready", host.keyready, 0);
        wait_idle(5 * (PRESS + GAP + 2) + 50);
        check("t3_keyready_back", host.keyready, 1);

        // Unmapped 'a' pulses badkey without a press, then '9' presses on column 2.
        column = 4'b1011;
        push_key(8'h61);
        push_key(8'h39);
        bad_n = 0; row_early = 0; press_n = 0;
        for (int i = 0; i < PRESS + GAP + 20; i++) begin
            @(negedge clk);
            if (badkey) bad_n++;
            if (row != 4'hF && bad_n == 0) row_early++;
            if (row == 4'b1011) press_n++;
        end
        check("t4_badkey_pulses", bad_n,     1);
        check("t4_row_before",    row_early, 0);
        check("t4_press_len",     press_n,   PRESS);
        wait_idle(20);

        // Reset at press clock 10 releases the key and drops the queue.
        column = 4'b0000;
        push_key(8'h37);
        push_key(8'h38);
        push_key(8'h39);
        wait_held(50);
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("t5_rst_row",      row,           4'hF);
        check("t5_rst_keyheld",  keyheld,       0);
        check("t5_rst_keyready", host.keyready, 1);
        check("t5_rst_busy",     busy,          0);
        resetn = 1'b1;
        stray = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (keyheld != 8'h00 || row != 4'hF || busy) stray++;
        end
        check("t5_queue_dropped", stray, 0);

        // 'D' held: own column low asserts row 3 regardless of other columns.
        column = 4'hF;
        push_key(8'h44);
        wait_held(50);
        column = 4'b0000; #1 check("t6_cols_all_low", row, 4'b0111);
        column = 4'b0111; #1 check("t6_col3_low",     row, 4'b0111);
        column = 4'b1111; #1 check("t6_cols_high",    row, 4'hF);
        column = 4'b1110; #1 check("t6_col0_low",     row, 4'hF);
        column = 4'hF;
        wait_idle(PRESS + GAP + 20);

        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
